// File: rtl/gadget_pkg.sv
// rtl/gadget_pkg.sv - shared state encoding and defaults for the gadget power sequencer
package gadget_pkg;

    localparam int GPOW_DATA_WIDTH = 32;
    localparam int GPOW_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STORE = 3'd4,
        ST_DONE  = 3'd5
    } gpow_state_t;

endpackage

// File: rtl/gadget_pow_seq.sv
// rtl/gadget_pow_seq.sv - builds pow[k] = Bg^k mod Q on one shared external multiplier
// Optional WAIT watchdog enabled by defining GPOW_TIMEOUT_EN.
module gadget_pow_seq
    import gadget_pkg::*;
#(
    parameter int DATA_WIDTH = GPOW_DATA_WIDTH,
    parameter int n_WIDTH    = 8,
    parameter int L          = 3,
    parameter int IDX_WIDTH  = 2
`ifdef GPOW_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = GPOW_TIMEOUT
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] Bg,
    input  logic signed [DATA_WIDTH-1:0] Q,
    output logic                         mm_start,
    output logic signed [DATA_WIDTH-1:0] mm_a,
    output logic signed [DATA_WIDTH-1:0] mm_b,
    output logic signed [DATA_WIDTH-1:0] mm_Q,
    input  logic                         mm_ready,
    input  logic                         mm_done,
    input  logic signed [DATA_WIDTH-1:0] mm_result,
    input  logic [IDX_WIDTH-1:0]         rd_idx,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int                   TBL    = 1 << IDX_WIDTH;
    localparam logic [IDX_WIDTH-1:0] K_LAST = IDX_WIDTH'(L - 1);
    localparam logic [IDX_WIDTH:0]   L_EXT  = (IDX_WIDTH + 1)'(L);

    gpow_state_t                  state, state_nxt;
    logic signed [DATA_WIDTH-1:0] bg_r, q_r, res_r;
    logic signed [DATA_WIDTH-1:0] pow_tbl [TBL];
    logic [IDX_WIDTH-1:0]         k;
    logic                         err_r;
    logic                         accept, capture, q_bad, timeout_hit;

    logic unused_n_width;
    assign unused_n_width = (n_WIDTH > 0);

    assign accept  = start && (state == ST_IDLE || state == ST_DONE);
    assign capture = (state == ST_WAIT) && mm_ready && mm_done;
    assign q_bad   = q_r[DATA_WIDTH-1] || (q_r == '0);

`ifdef GPOW_TIMEOUT_EN
    logic [15:0] wd_cnt;
    assign timeout_hit = (state == ST_WAIT) && !capture && (wd_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mm_start  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_LOAD;
            ST_LOAD: begin
                busy      = 1'b1;
                state_nxt = q_bad ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                mm_start  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (capture)          state_nxt = ST_STORE;
                else if (timeout_hit) state_nxt = ST_DONE;
            end
            ST_STORE: begin
                busy      = 1'b1;
                state_nxt = (k == K_LAST) ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_LOAD;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Every run starts from a cleared table so aborted runs leave zeros behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_r  <= '0;
            q_r   <= '0;
            res_r <= '0;
            k     <= IDX_WIDTH'(1);
            err_r <= 1'b0;
            for (int i = 0; i < TBL; i++) pow_tbl[i] <= '0;
        end else begin
            if (accept) begin
                bg_r  <= Bg;
                q_r   <= Q;
                err_r <= 1'b0;
            end
            case (state)
                ST_LOAD: begin
                    k <= IDX_WIDTH'(1);
                    for (int i = 0; i < TBL; i++) pow_tbl[i] <= '0;
                    if (q_bad) err_r <= 1'b1;
                    else       pow_tbl[0] <= (q_r == DATA_WIDTH'(1)) ? '0 : DATA_WIDTH'(1);
                end
                ST_WAIT: begin
                    if (capture)     res_r <= mm_result;
                    if (timeout_hit) err_r <= 1'b1;
                end
                ST_STORE: begin
                    pow_tbl[k] <= res_r;
                    if (k != K_LAST) k <= k + IDX_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign mm_a    = pow_tbl[k - IDX_WIDTH'(1)];
    assign mm_b    = bg_r;
    assign mm_Q    = q_r;
    assign err     = err_r;
    assign rd_data = ({1'b0, rd_idx} < L_EXT) ? pow_tbl[rd_idx] : '0;

endmodule

// File: tb/tb_gadget_pow_seq.sv
// tb/tb_gadget_pow_seq.sv - randomized self-checking bench for gadget_pow_seq
module tb_gadget_pow_seq;

    localparam int L          = 3;
    localparam int TB_TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] Bg = '0, Q = '0;
    logic               mm_start;
    logic signed [31:0] mm_a, mm_b, mm_Q;
    logic               mm_ready = 1'b0, mm_done = 1'b0;
    logic signed [31:0] mm_result = '0;
    logic [1:0]         rd_idx = '0;
    logic signed [31:0] rd_data;
    logic               busy, done, err;

    int checks = 0;
    int failures = 0;

    gadget_pow_seq #(
        .DATA_WIDTH(32), .n_WIDTH(8), .L(L), .IDX_WIDTH(2)
`ifdef GPOW_TIMEOUT_EN
        , .TIMEOUT(TB_TIMEOUT)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .Bg(Bg), .Q(Q),
        .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_Q(mm_Q),
        .mm_ready(mm_ready), .mm_done(mm_done), .mm_result(mm_result),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic longint modmul(input longint a, input longint b, input longint q);
        longint r;
        r = (a * b) % q;
        if (r < 0) r += q;
        return r;
    endfunction

    function automatic longint model_pow(input longint bg, input longint q, input int k);
        longint p;
        if (q <= 0) return 0;
        p = (q == 1) ? 0 : 1;
        for (int i = 0; i < k; i++) p = modmul(p, bg, q);
        return p;
    endfunction

    // Expected table, published once a run has completed
    longint exp_tbl [4];
    bit     exp_err;
    bit     exp_valid = 0;
    bit     rd_hold = 0;

    // Behavioural multiplier: result becomes valid M cycles after the mm_start cycle
    int     mm_lat = 5;
    bit     mm_early = 0;
    bit     mm_never = 0;
    int     mm_pulses = 0;
    int     mm_cnt = 0;
    bit     mm_act = 0;
    longint ma, mb, mq;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            mm_act = 0; mm_done = 0; mm_ready = 0;
        end else begin
            if (mm_act) begin
                if (mm_done && mm_ready) begin
                    mm_act = 0; mm_done = 0; mm_ready = 0;
                end else begin
                    mm_cnt--;
                    if (mm_cnt == 0 && !mm_never) begin
                        mm_done = 1; mm_ready = 1;
                        mm_result = 32'(modmul(ma, mb, mq));
                    end else if (mm_cnt == 1 && mm_early) begin
                        mm_done = 1; mm_ready = 0;
                        mm_result = 32'h0000_dead;
                    end else begin
                        mm_done = 0; mm_ready = 0;
                    end
                end
            end
            if (mm_start) begin
                mm_act = 1; mm_cnt = mm_lat; mm_done = 0; mm_ready = 0;
                ma = mm_a; mb = mm_b; mq = mm_Q;
                mm_pulses++;
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (!rd_hold) rd_idx = 2'($urandom_range(0, 3));
    end

    // Per-cycle compare against the published expectation
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (mm_start) chk("mm_start_while_busy", busy, 1);
            if (done) chk("done_not_busy", busy, 0);
            if (done && exp_valid) begin
                chk("rd_data_cycle", rd_data, (rd_idx < L) ? exp_tbl[rd_idx] : 0);
                chk("err_cycle", err, exp_err);
            end
        end
    end

    task automatic sweep(input longint e0, input longint e1, input longint e2, input string tag);
        longint e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = 0;
        @(negedge clk);
        rd_hold = 1;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i); #1;
            chk($sformatf("%s_rd%0d", tag, i), rd_data, e[i]);
        end
        rd_hold = 0;
    endtask

    task automatic run_seq(input int bg, input int q, input int m, input bit early,
                           input int repulse_at, input string tag);
        int lat, exp_lat, exp_pulses, p0;
        bit e_err;
        @(negedge clk);
        exp_valid = 0;
        Bg = bg; Q = q; mm_lat = m; mm_early = early;
        p0 = mm_pulses;
        start = 1;
        lat = -1;
        if (q <= 0) begin
            exp_lat = 2; exp_pulses = 0; e_err = 1;
        end else if (mm_never) begin
            exp_lat = 3 + TB_TIMEOUT; exp_pulses = 1; e_err = 1;
        end else begin
            exp_lat = 2 + (L - 1) * (m + 2); exp_pulses = L - 1; e_err = 0;
        end
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            start = 0; Bg = bg;
            if (n == repulse_at) begin start = 1; Bg = 5; end
            if (done) begin lat = n; break; end
        end
        start = 0; Bg = bg;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_mm_pulses"}, mm_pulses - p0, exp_pulses);
        chk({tag, "_err"}, err, e_err);
        for (int i = 0; i < 4; i++)
            exp_tbl[i] = (i < L && (!mm_never || i == 0)) ? model_pow(bg, q, i) : 0;
        exp_err = e_err;
        exp_valid = 1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int p0, bg, q, m, kind, el;

        chk("model_pow1", model_pow(1024, 12289, 1), 1024);
        chk("model_pow2", model_pow(1024, 12289, 2), 4011);
        chk("model_pow3", model_pow(1024, 12289, 3), 2738);
        chk("model_q1",   model_pow(77, 1, 0), 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mm_start", mm_start, 0);
        chk("rst_mm_a", mm_a, 0);
        chk("rst_mm_b", mm_b, 0);
        chk("rst_mm_Q", mm_Q, 0);
        sweep(0, 0, 0, "rst");
        @(negedge clk); rst = 0;

        run_seq(1024, 12289, 5, 0, 0, "base");
        sweep(1, 1024, 4011, "base");
        run_seq(0, 0, 5, 0, 0, "q_zero");
        sweep(0, 0, 0, "q_zero");
        run_seq(1024, -7, 5, 0, 0, "q_neg");
        sweep(0, 0, 0, "q_neg");
        run_seq(1024, 12289, 5, 0, 5, "repulse");
        sweep(1, 1024, 4011, "repulse");
        run_seq(1024, 12289, 3, 1, 0, "early_done");
        run_seq(9, 1, 2, 0, 0, "q_one");

        // Reset during the second WAIT, then a clean rerun
        @(negedge clk);
        exp_valid = 0;
        Bg = 1024; Q = 12289; mm_lat = 5; mm_early = 0; start = 1;
        p0 = mm_pulses;
        @(negedge clk); start = 0;
        for (int n = 0; n < 100 && mm_pulses < p0 + 2; n++) @(negedge clk);
        chk("rst_mid_second_issue", mm_pulses - p0, 2);
        @(negedge clk); @(negedge clk);
        rd_hold = 1; rd_idx = 2'd1;
        rst = 1;
        @(posedge clk); #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_err", err, 0);
        chk("rst_mid_mm_start", mm_start, 0);
        chk("rst_mid_mm_a", mm_a, 0);
        chk("rst_mid_mm_b", mm_b, 0);
        chk("rst_mid_mm_Q", mm_Q, 0);
        chk("rst_mid_rd1", rd_data, 0);
        rd_hold = 0;
        @(negedge clk); @(negedge clk); rst = 0;
        run_seq(1024, 12289, 5, 0, 0, "after_rst");
        sweep(1, 1024, 4011, "after_rst");

        for (int r = 0; r < 24; r++) begin
            kind = $urandom_range(0, 9);
            bg = int'($urandom);
            if (kind == 0)      q = -int'($urandom_range(0, 1000));
            else if (kind == 1) q = 1;
            else                q = int'($urandom_range(2, 32'h7fff_ffff));
            m = $urandom_range(1, 6);
            el = 2 + (L - 1) * (m + 2);
            run_seq(bg, q, m, 1'($urandom_range(0, 1)),
                    (q > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, el - 1)) : 0,
                    $sformatf("rand%0d", r));
        end

`ifdef GPOW_TIMEOUT_EN
        mm_never = 1;
        run_seq(1024, 12289, 5, 0, 0, "timeout");
        sweep(1, 0, 0, "timeout");
        mm_never = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
